// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter
//   Two-master arbiter (instruction fetch + data port) in front of a single
//   unified memory port. One access is in flight at a time. Each access goes
//   IDLE -> BUSY -> RESP -> IDLE. An access ends on mem_ack or, when TIMEOUT
//   is nonzero, after TIMEOUT busy cycles without an acknowledge (ack + err).
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   TIMEOUT  busy cycles allowed before the access is abandoned (0 = wait forever)
//
// Build option
//   ARB_ROUND_ROBIN_EN  defined: simultaneous requests go to the master that
//                       was not granted last. Undefined: the data port always
//                       wins over instruction fetch.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   if_req, if_addr                   fetch request / address (held until if_ack)
//   if_rdata, if_ack                  fetched word and one-cycle completion pulse
//   d_req, d_we, d_addr, d_wdata      data request (held until d_ack)
//   d_rdata, d_ack                    load data (0 for stores) and completion pulse
//   err                               set together with an ack when the access timed out
//   cpu_stall                         combinational stall towards the CPU
//   mem_req, mem_we, mem_addr,
//   mem_wdata                         registered request to the unified memory
//   mem_rdata, mem_ack                memory read data and one-cycle completion
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              err,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // The counter only has to reach TIMEOUT-1 (last busy cycle before expiry).
    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic            TO_EN    = (TIMEOUT > 0);

    state_t              state_reg, state_next;
    logic                owner_reg, owner_next;     // also serves as last-grant
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                mem_req_reg, mem_req_next;
    logic                mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
    logic                if_ack_reg, if_ack_next;
    logic                d_ack_reg, d_ack_next;
    logic [DATA_W-1:0]   if_rdata_reg, if_rdata_next;
    logic [DATA_W-1:0]   d_rdata_reg, d_rdata_next;
    logic                err_reg, err_next;

    logic                req_any;
    logic                grant_d;
    logic                timeout_hit;

    // ------------------------------------------------------------------
    // Arbitration (only consulted in IDLE)
    // ------------------------------------------------------------------
    always_comb begin
        req_any = if_req | d_req;
`ifdef ARB_ROUND_ROBIN_EN
        // On a tie, the data port wins only if fetch owned the last access.
        grant_d = d_req & (~if_req | (owner_reg == OWN_IF));
`else
        grant_d = d_req;
`endif
    end

    // Expiry fires on the TIMEOUT-th busy cycle; mem_ack in that same cycle
    // takes precedence in the output logic below.
    assign timeout_hit = TO_EN & (cnt_reg == CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (req_any) state_next = ST_BUSY;
            ST_BUSY: if (mem_ack || timeout_hit) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        owner_next     = owner_reg;
        cnt_next       = cnt_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        // Acks, read data and err are single-cycle: zero unless entering RESP.
        if_ack_next    = 1'b0;
        d_ack_next     = 1'b0;
        if_rdata_next  = '0;
        d_rdata_next   = '0;
        err_next       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (req_any) begin
                    owner_next     = grant_d ? OWN_D : OWN_IF;
                    cnt_next       = '0;
                    mem_req_next   = 1'b1;
                    mem_addr_next  = grant_d ? d_addr : if_addr;
                    mem_we_next    = grant_d & d_we;
                    mem_wdata_next = grant_d ? d_wdata : '0;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    if (owner_reg == OWN_D) begin
                        d_ack_next   = 1'b1;
                        d_rdata_next = mem_we_reg ? '0 : mem_rdata;
                    end else begin
                        if_ack_next   = 1'b1;
                        if_rdata_next = mem_rdata;
                    end
                end else if (timeout_hit) begin
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    err_next     = 1'b1;
                    if (owner_reg == OWN_D) begin
                        d_ack_next = 1'b1;
                    end else begin
                        if_ack_next = 1'b1;
                    end
                end else if (TO_EN) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg     <= OWN_IF;
            cnt_reg       <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_ack_reg    <= 1'b0;
            d_ack_reg     <= 1'b0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
            err_reg       <= 1'b0;
        end else begin
            owner_reg     <= owner_next;
            cnt_reg       <= cnt_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            if_ack_reg    <= if_ack_next;
            d_ack_reg     <= d_ack_next;
            if_rdata_reg  <= if_rdata_next;
            d_rdata_reg   <= d_rdata_next;
            err_reg       <= err_next;
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_ack    = if_ack_reg;
    assign d_ack     = d_ack_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign err       = err_reg;

    assign cpu_stall = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles mem_req waits for mem_ack (0 = no limit).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 if_req  in  1  instruction fetch request, held until if_ack.
REQ-008 if_addr  in  ADDR_W  fetch address.
REQ-009 if_rdata  out  DATA_W  fetched word, valid with if_ack.
REQ-010 if_ack  out  1  one-cycle fetch completion pulse.
REQ-011 d_req  in  1  data request, held until d_ack.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  ADDR_W  data address.
REQ-014 d_wdata  in  DATA_W  store data.
REQ-015 d_rdata  out  DATA_W  load data, valid with d_ack.
REQ-016 d_ack  out  1  one-cycle data completion pulse.
REQ-017 err  out  1  with an ack pulse, flags a timed-out access.
REQ-018 cpu_stall  out  1  combinational (if_req & ~if_ack) | (d_req & ~d_ack).
REQ-019 mem_req, mem_we  out  1  registered unified-memory request and write enable.
REQ-020 mem_addr, mem_wdata  out  ADDR_W/DATA_W  registered, latched at grant.
REQ-021 mem_rdata  in  DATA_W; mem_ack  in  1  memory completion, one cycle.

Function
REQ-022 States SHALL be IDLE, BUSY, RESP; grant register SHALL record owner (IF or D).
REQ-023 IDLE: a request asserted in cycle N SHALL latch owner, address, we, wdata and move to BUSY; mem_req=1 from cycle N+1.
REQ-024 IF-granted accesses SHALL drive mem_we=0 and mem_wdata=0.
REQ-025 BUSY: mem_req and latched fields SHALL stay constant until mem_ack; on mem_ack in cycle M, mem_req=0 from M+1, data captured, state RESP.
REQ-026 RESP: owner's ack=1 for exactly one cycle (M+1) with captured rdata; then IDLE; the non-owner's ack SHALL stay 0.
REQ-027 Store completion SHALL return d_rdata=0.
REQ-028 Zero-wait memory SHALL give request-to-ack latency of 2 cycles, one access per 3 cycles.
REQ-029 Requesters SHALL drop req in the cycle after ack; a req still high in IDLE is a new request.
REQ-030 mem_ack in IDLE or RESP SHALL be ignored.
REQ-031 Input changes by a non-granted requester SHALL have no effect before IDLE.
REQ-032 TIMEOUT>0: cycle counter SHALL count BUSY cycles; at TIMEOUT cycles without mem_ack, mem_req=0, RESP with err=1 and rdata=0.
REQ-033 mem_ack in the same cycle as timeout expiry SHALL win: normal completion, err=0.
REQ-034 err SHALL be 0 outside RESP.
REQ-035 Simultaneous if_req and d_req in IDLE SHALL be resolved per REQ-039.

Reset
REQ-036 rst SHALL force IDLE, counter 0, last-grant = IF, and all registered outputs (mem_*, acks, rdata, err) to 0 at the next edge.
REQ-037 rst mid-BUSY/RESP SHALL abandon the access with no ack issued.

Configuration
REQ-038 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-039 Defined: simultaneous requests granted to the requester not granted last; undefined: D always wins over IF.

Verification
REQ-040 if_req=1 addr 0x0000_0040, mem_ack one cycle after mem_req, mem_rdata 0x2402_0005 -> if_ack in cycle 2 with if_rdata 0x2402_0005, err=0.
REQ-041 if_req and d_req (store 0x1234 to 0x100) in same cycle, macro undefined -> store granted first, mem_we=1, then fetch; macro defined after prior D grant -> fetch first.
REQ-042 Load with mem_ack withheld, TIMEOUT=4 -> mem_req drops after 4 BUSY cycles, d_ack=1, err=1, d_rdata=0.
REQ-043 mem_ack coincident with TIMEOUT expiry -> normal ack, err=0, mem_rdata returned.
REQ-044 rst asserted during BUSY -> next edge mem_req=0, IDLE, no ack; fresh if_req served normally.
REQ-045 Spurious mem_ack in IDLE, d_addr changed while IF granted -> no ack, latched mem_addr unchanged.
